// File: rtl/prog_loader.sv
// Program loader: fills a 16x8 instruction store from a byte stream,
// optionally verifies a trailing checksum, then releases the CPU from reset.
// The CPU fetches combinationally through PC -> {A, D}.
module prog_loader #(
  parameter int CHK_EN = 1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       start,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  input  logic [3:0] PC,
  output logic [3:0] A,
  output logic [3:0] D,
  output logic       cpu_rst,
  output logic       busy,
  output logic       done,
  output logic       err
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    CHK  = 3'd2,
    RUN  = 3'd3,
    ERR  = 3'd4
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  addr;
  logic [7:0]  sum;
  logic [7:0]  mem [16];
  logic        xfer;
  logic        load_go;
  logic [7:0]  sum_chk;

  // A byte moves only when both sides agree; in_ready is state-decoded.
  assign xfer    = in_valid & in_ready;
  // A new load may only be requested from a quiescent state.
  assign load_go = start & ((state == IDLE) | (state == RUN) | (state == ERR));
  assign sum_chk = sum + in_data;

  // State register
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, RUN, ERR: begin
        if (start) state_nxt = LOAD;
      end
      LOAD: begin
        if (xfer && (addr == 4'd15)) state_nxt = (CHK_EN != 0) ? CHK : RUN;
      end
      CHK: begin
        if (xfer) state_nxt = (sum_chk == 8'h00) ? RUN : ERR;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Write address and running checksum; addr wraps naturally after word 15
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      addr <= 4'd0;
      sum  <= 8'h00;
    end else if (load_go) begin
      addr <= 4'd0;
      sum  <= 8'h00;
    end else if ((state == LOAD) && xfer) begin
      addr <= addr + 4'd1;
      sum  <= sum + in_data;
    end
  end

  // Instruction store: cleared by reset, written only during LOAD
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < 16; i++) mem[i] <= 8'h00;
    end else if ((state == LOAD) && xfer) begin
      mem[addr] <= in_data;
    end
  end

  // Fetch port is combinational in every state
  assign A = mem[PC][7:4];
  assign D = mem[PC][3:0];

  // Status outputs are pure state decodes
  assign in_ready = (state == LOAD) | (state == CHK);
  assign busy     = (state == LOAD) | (state == CHK);
  assign cpu_rst  = (state == RUN);
  assign done     = (state == RUN);
  assign err      = (state == ERR);

endmodule
